// File: rtl/bypass_scoreboard.sv
// Operand forwarding and hazard detection between ID and the post-ID stages, with a
// per-register count of in-flight writers so that writers hidden from the stage buses still stall ID.
module bypass_scoreboard #(
   parameter int NUM_STAGES   = 3,
   parameter int NUM_RD_PORTS = 2,
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int CNT_W        = $clog2(NUM_STAGES + 2)
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             id_issue_i,
   input  logic                             id_dst_wen_i,
   input  logic [ADDR_W-1:0]                id_dst_addr_i,
   input  logic [NUM_RD_PORTS*ADDR_W-1:0]   id_src_addr_i,
   input  logic [NUM_RD_PORTS-1:0]          id_src_used_i,
   input  logic [NUM_STAGES-1:0]            st_wen_i,
   input  logic [NUM_STAGES*ADDR_W-1:0]     st_addr_i,
   input  logic [NUM_STAGES*DATA_W-1:0]     st_data_i,
   input  logic [NUM_STAGES-1:0]            st_dvalid_i,
   input  logic                             wb_retire_i,
   input  logic                             flush_i,
   input  logic [NUM_STAGES-1:0]            flush_mask_i,
   output logic [NUM_RD_PORTS*DATA_W-1:0]   fwd_data_o,
   output logic [NUM_RD_PORTS-1:0]          fwd_hit_o,
   output logic                             stall_o,
   output logic [31:0]                      stall_cnt_o,
   output logic                             sb_err_o
);
   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam logic signed [CNT_W+1:0] CNT_MAX = (CNT_W+2)'((2 ** CNT_W) - 1);

   logic [CNT_W-1:0]        cnt [NUM_REGS];
   logic [NUM_REGS-1:0]     reg_err;
   logic [NUM_RD_PORTS-1:0] port_stall;
   logic                    stall;
   logic                    issue_ok;
   logic                    issue_err;
   logic [31:0]             stall_cnt_reg;
   logic                    sb_err_reg;

   for (genvar gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              hit;
      logic              pstall;
      logic              found;

      assign addr = id_src_addr_i[gp*ADDR_W +: ADDR_W];

      // Stages are scanned youngest first; the first match shadows older ones.
      always_comb begin
         hit    = 1'b0;
         data   = '0;
         pstall = 1'b0;
         found  = 1'b0;
         if (addr == '0) begin
            hit = 1'b1;
         end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
               if (!found && st_wen_i[s] && st_addr_i[s*ADDR_W +: ADDR_W] == addr) begin
                  found = 1'b1;
                  if (st_dvalid_i[s]) begin
                     hit  = 1'b1;
                     data = st_data_i[s*DATA_W +: DATA_W];
                  end else begin
                     pstall = 1'b1;
                  end
               end
            end
            if (!found && cnt[addr] != '0)
               pstall = 1'b1;
         end
      end

      assign fwd_hit_o[gp]                   = hit;
      assign fwd_data_o[gp*DATA_W +: DATA_W] = data;
      assign port_stall[gp]                  = id_src_used_i[gp] && pstall;
   end

   assign stall     = |port_stall;
   assign issue_ok  = id_issue_i && !flush_i && !stall && id_dst_wen_i && id_dst_addr_i != '0;
   assign issue_err = id_issue_i && !flush_i && stall;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign cnt[gi]     = '0;
         assign reg_err[gi] = 1'b0;
      end else begin : g_cnt
         logic [CNT_W-1:0]        cnt_reg;
         logic [CNT_W-1:0]        cnt_next;
         logic [CNT_W:0]          dec_n;
         logic signed [CNT_W+1:0] sum;
         logic                    inc;
         logic                    err;

         assign inc = issue_ok && id_dst_addr_i == ADDR_W'(gi);

         // A stage that is both retired and flushed is one writer leaving, so it counts once.
         always_comb begin
            dec_n = '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
               if (st_wen_i[s] && st_addr_i[s*ADDR_W +: ADDR_W] == ADDR_W'(gi) &&
                   ((flush_i && flush_mask_i[s]) || (s == NUM_STAGES - 1 && wb_retire_i)))
                  dec_n = dec_n + (CNT_W+1)'(1);
            end
            sum = $signed({2'b00, cnt_reg}) + $signed({{(CNT_W+1){1'b0}}, inc})
                  - $signed({1'b0, dec_n});
            err      = 1'b0;
            cnt_next = sum[CNT_W-1:0];
            if (sum[CNT_W+1]) begin
               err      = 1'b1;
               cnt_next = '0;
            end else if (sum > CNT_MAX) begin
               err      = 1'b1;
               cnt_next = '1;
            end
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) cnt_reg <= '0;
            else         cnt_reg <= cnt_next;
         end

         assign cnt[gi]     = cnt_reg;
         assign reg_err[gi] = err;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt_reg <= '0;
         sb_err_reg    <= 1'b0;
      end else begin
         if (stall && stall_cnt_reg != '1)
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (issue_err || (|reg_err))
            sb_err_reg <= 1'b1;
      end
   end

   assign stall_o     = stall;
   assign stall_cnt_o = stall_cnt_reg;
   assign sb_err_o    = sb_err_reg;
endmodule
